// File: rtl/sha_message_build_param.sv
// SHA-2 message padder: passes raw blocks through and appends the '1' bit, zero fill and
// big-endian length field, inserting an extra block when the pad does not fit.
module sha_message_build_param #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned LEN_W   = 64
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [LEN_W-1:0]   cfg_size,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_in_last,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               data_out_last,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               err_mismatch
);

  localparam int unsigned OffW = $clog2(BLOCK_W);
  localparam int unsigned VW   = OffW + 1;

  typedef enum logic [1:0] {StCfg, StData, StExtra} state_e;

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_blk_cnt;
  logic               r_extra_one;

  logic               w_slot_free;
  logic [OffW-1:0]    w_rem;
  logic [VW-1:0]      w_v;
  logic               w_full;
  logic               w_fits;
  logic [BLOCK_W-1:0] w_keep_mask;
  logic [BLOCK_W-1:0] w_one_bit;
  logic [BLOCK_W-1:0] w_len_blk;
  logic [BLOCK_W-1:0] w_pad_blk;
  logic [BLOCK_W-1:0] w_extra_blk;
  logic [LEN_W:0]     w_blk_ceil;
  logic [LEN_W:0]     w_exp_cnt;
  logic [LEN_W:0]     w_cnt_p1;
  logic               w_mismatch;

  assign w_slot_free   = !data_out_valid || data_out_ready;
  // Ready lines are forced low while reset is held so the reset values are visible.
  assign cfg_ready     = (r_state == StCfg) && !nrst;
  assign data_in_ready = (r_state == StData) && w_slot_free && !nrst;

  assign w_rem  = r_len[OffW-1:0];
  assign w_v    = ((w_rem == '0) && (r_len != '0)) ? VW'(BLOCK_W) : {1'b0, w_rem};
  assign w_full = (w_v == VW'(BLOCK_W));
  assign w_fits = (w_v <= VW'(BLOCK_W - 1 - LEN_W));

  // A shift by BLOCK_W yields an all-ones keep mask and no marker bit, so a full last
  // block passes through untouched and the marker moves into the extra block.
  assign w_keep_mask = ~({BLOCK_W{1'b1}} >> w_v);
  assign w_one_bit   = {1'b1, {(BLOCK_W-1){1'b0}}} >> w_v;
  assign w_len_blk   = {{(BLOCK_W-LEN_W){1'b0}}, r_len};
  assign w_pad_blk   = (data_in & w_keep_mask) | w_one_bit | (w_fits ? w_len_blk : '0);
  assign w_extra_blk = (r_extra_one ? {1'b1, {(BLOCK_W-1){1'b0}}} : '0) | w_len_blk;

  assign w_blk_ceil = (LEN_W+1)'(r_len >> OffW) + (LEN_W+1)'(w_rem != '0);
  assign w_exp_cnt  = (w_blk_ceil == '0) ? (LEN_W+1)'(1) : w_blk_ceil;
  assign w_cnt_p1   = {1'b0, r_blk_cnt} + (LEN_W+1)'(1);
  assign w_mismatch = (w_cnt_p1 != w_exp_cnt);

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state        <= StCfg;
      r_len          <= '0;
      r_blk_cnt      <= '0;
      r_extra_one    <= 1'b0;
      data_out       <= '0;
      data_out_last  <= 1'b0;
      data_out_valid <= 1'b0;
      err_mismatch   <= 1'b0;
    end else begin
      err_mismatch <= 1'b0;
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      case (r_state)
        StCfg: begin
          if (cfg_valid) begin
            r_len     <= cfg_size;
            r_blk_cnt <= '0;
            r_state   <= StData;
          end
        end
        StData: begin
          if (data_in_valid && w_slot_free) begin
            data_out_valid <= 1'b1;
            if (!data_in_last) begin
              data_out      <= data_in;
              data_out_last <= 1'b0;
              if (r_blk_cnt != '1) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
              end
            end else begin
              data_out      <= w_pad_blk;
              data_out_last <= w_fits;
              err_mismatch  <= w_mismatch;
              r_extra_one   <= w_full;
              r_state       <= w_fits ? StCfg : StExtra;
            end
          end
        end
        StExtra: begin
          if (w_slot_free) begin
            data_out       <= w_extra_blk;
            data_out_last  <= 1'b1;
            data_out_valid <= 1'b1;
            r_state        <= StCfg;
          end
        end
        default: r_state <= StCfg;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_message_build_param.sv
// Bench for the SHA-2 padder: drives 512- and 1024-bit instances and compares their output
// streams with a bit-level padding model.
module tb_sha_message_build_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst;
  logic [127:0]  cfg_size;
  logic [1023:0] data_in;
  logic          din_last;
  logic [1:0]    cfg_valid, din_valid, dout_ready;
  logic [1:0]    cfg_ready, din_ready, dout_last, dout_valid, err;
  logic [511:0]  dout0;
  logic [1023:0] dout1;

  sha_message_build_param #(.BLOCK_W(512), .LEN_W(64)) u_dut512 (
    .clk(clk), .nrst(nrst), .cfg_size(cfg_size[63:0]), .cfg_valid(cfg_valid[0]),
    .cfg_ready(cfg_ready[0]), .data_in(data_in[511:0]), .data_in_last(din_last),
    .data_in_valid(din_valid[0]), .data_in_ready(din_ready[0]), .data_out(dout0),
    .data_out_last(dout_last[0]), .data_out_valid(dout_valid[0]),
    .data_out_ready(dout_ready[0]), .err_mismatch(err[0])
  );

  sha_message_build_param #(.BLOCK_W(1024), .LEN_W(128)) u_dut1024 (
    .clk(clk), .nrst(nrst), .cfg_size(cfg_size), .cfg_valid(cfg_valid[1]),
    .cfg_ready(cfg_ready[1]), .data_in(data_in), .data_in_last(din_last),
    .data_in_valid(din_valid[1]), .data_in_ready(din_ready[1]), .data_out(dout1),
    .data_out_last(dout_last[1]), .data_out_valid(dout_valid[1]),
    .data_out_ready(dout_ready[1]), .err_mismatch(err[1])
  );

  typedef struct {
    logic [1023:0] d;
    logic          l;
  } blk_t;

  blk_t          outq[$];
  blk_t          expq[$];
  logic [1023:0] msgq[$];
  int            n_tests, n_fail, err_seen, exp_err, stab_bad;
  bit            bp;
  bit            prev_stall[2];
  logic [1023:0] prev_d[2];
  logic          prev_l[2];

  function automatic logic [1023:0] out_data(input int g);
    return (g != 0) ? dout1 : {512'b0, dout0};
  endfunction

  function automatic logic [1023:0] rand_blk(input int g);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    if (g == 0) r[1023:512] = '0;
    return r;
  endfunction

  // Model: message bits, then the '1' marker at offset v, then the length in the low bits of
  // whichever block (last or one past it) has room for it.
  function automatic void build_expect(input int g, input logic [127:0] L);
    int            bw = (g != 0) ? 1024 : 512;
    int            lw = (g != 0) ? 128 : 64;
    int            n  = msgq.size();
    int            v;
    longint        e;
    logic [2047:0] pbuf;
    logic [1023:0] last, mask;
    blk_t          b;
    expq.delete();
    for (int i = 0; i < n - 1; i++) begin
      b.d = msgq[i]; b.l = 1'b0; expq.push_back(b);
    end
    last = msgq[n-1];
    v = int'(L % bw);
    if (v == 0 && L != 0) v = bw;
    pbuf = '0;
    for (int i = 0; i < v; i++) pbuf[2*bw-1-i] = last[bw-1-i];
    pbuf[2*bw-1-v] = 1'b1;
    mask = (bw == 1024) ? {1024{1'b1}} : {512'b0, {512{1'b1}}};
    if (v + 1 + lw <= bw) begin
      pbuf = pbuf | (2048'(L) << bw);
      b.d = 1024'(pbuf >> bw); b.l = 1'b1; expq.push_back(b);
    end else begin
      pbuf = pbuf | 2048'(L);
      b.d = 1024'(pbuf >> bw); b.l = 1'b0; expq.push_back(b);
      b.d = pbuf[1023:0] & mask; b.l = 1'b1; expq.push_back(b);
    end
    e = longint'((L + 128'(bw) - 1) / bw);
    if (e == 0) e = 1;
    exp_err = (longint'(n) != e) ? 1 : 0;
  endfunction

  task automatic tick(input int g, output bit cfg_acc, output bit din_acc);
    blk_t b;
    dout_ready = 2'b11;
    if (bp) dout_ready[g] = 1'($urandom_range(0, 1));
    #1;
    if (prev_stall[g] && (dout_valid[g] !== 1'b1 || out_data(g) !== prev_d[g] ||
                          dout_last[g] !== prev_l[g])) stab_bad++;
    cfg_acc = cfg_valid[g] & cfg_ready[g];
    din_acc = din_valid[g] & din_ready[g];
    if (dout_valid[g] && dout_ready[g]) begin
      b.d = out_data(g); b.l = dout_last[g]; outq.push_back(b);
    end
    prev_stall[g] = dout_valid[g] && !dout_ready[g];
    prev_d[g] = out_data(g);
    prev_l[g] = dout_last[g];
    if (err[g]) err_seen++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cfg(input int g, input logic [127:0] L);
    bit ca, da;
    int k = 0;
    cfg_size = L;
    cfg_valid[g] = 1'b1;
    do begin tick(g, ca, da); k++; end while (!ca && k < 100);
    if (!ca) begin
      n_tests++; n_fail++;
      $display("FAIL cfg_timeout g=%0d actual=not accepted required=accepted", g);
    end
    cfg_valid[g] = 1'b0;
  endtask

  task automatic send_beats(input int g, input int first, input int count);
    bit ca, da;
    int k;
    for (int i = first; i < first + count; i++) begin
      data_in = msgq[i];
      din_last = (i == msgq.size() - 1);
      din_valid[g] = 1'b1;
      k = 0;
      do begin tick(g, ca, da); k++; end while (!da && k < 100);
      if (!da) begin
        n_tests++; n_fail++;
        $display("FAIL beat_timeout g=%0d beat=%0d actual=not accepted required=accepted", g, i);
      end
    end
    din_valid[g] = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic drain(input int g);
    bit ca, da;
    int k = 0;
    while (outq.size() < expq.size() && k < 200) begin tick(g, ca, da); k++; end
    repeat (3) tick(g, ca, da);
  endtask

  task automatic send_msg(input int g, input logic [127:0] L);
    outq.delete();
    err_seen = 0;
    build_expect(g, L);
    send_cfg(g, L);
    send_beats(g, 0, msgq.size());
    drain(g);
  endtask

  task automatic test_reset;
    for (int g = 0; g < 2; g++) begin
      n_tests += 6;
      if (cfg_ready[g] !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_ready g=%0d actual=%b required=0", g, cfg_ready[g]); end
      if (din_ready[g] !== 1'b0) begin n_fail++; $display("FAIL rst_din_ready g=%0d actual=%b required=0", g, din_ready[g]); end
      if (dout_valid[g] !== 1'b0) begin n_fail++; $display("FAIL rst_valid g=%0d actual=%b required=0", g, dout_valid[g]); end
      if (dout_last[g] !== 1'b0) begin n_fail++; $display("FAIL rst_last g=%0d actual=%b required=0", g, dout_last[g]); end
      if (err[g] !== 1'b0) begin n_fail++; $display("FAIL rst_err g=%0d actual=%b required=0", g, err[g]); end
      if (out_data(g) !== '0) begin n_fail++; $display("FAIL rst_data g=%0d actual=%h required=0", g, out_data(g)); end
    end
    nrst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_tests++;
      if (cfg_ready[g] !== 1'b1) begin n_fail++; $display("FAIL post_rst_cfg_ready g=%0d actual=%b required=1", g, cfg_ready[g]); end
    end
  endtask

  task automatic test_vectors;
    int            g;
    logic [127:0]  L;
    logic [1023:0] blk, lit;
    bp = 1'b0;
    for (int t = 0; t < 5; t++) begin
      msgq.delete();
      case (t)
        0: begin g = 0; L = 24; blk = '0; blk[511:488] = 24'h616263; msgq.push_back(blk); end
        1: begin g = 0; L = 448; msgq.push_back(rand_blk(0)); end
        2: begin g = 0; L = 1024; msgq.push_back(rand_blk(0)); msgq.push_back(rand_blk(0)); end
        3: begin g = 1; L = 0; msgq.push_back({1024{1'b1}}); end
        default: begin g = 0; L = 24; msgq.push_back(rand_blk(0)); msgq.push_back(rand_blk(0)); end
      endcase
      send_msg(g, L);
      n_tests++;
      if (outq.size() != expq.size()) begin
        n_fail++; $display("FAIL vec%0d_count actual=%0d required=%0d", t, outq.size(), expq.size());
      end
      for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
        n_tests++;
        if (outq[i].d !== expq[i].d || outq[i].l !== expq[i].l) begin
          n_fail++;
          $display("FAIL vec%0d_blk%0d actual=%h..%h/%b required=%h..%h/%b", t, i,
                   outq[i].d[511:448], outq[i].d[63:0], outq[i].l,
                   expq[i].d[511:448], expq[i].d[63:0], expq[i].l);
        end
      end
      n_tests += 2;
      if (err_seen != exp_err) begin n_fail++; $display("FAIL vec%0d_err actual=%0d required=%0d", t, err_seen, exp_err); end
      if (cfg_ready[g] !== 1'b1) begin n_fail++; $display("FAIL vec%0d_back_to_cfg actual=%b required=1", t, cfg_ready[g]); end
      if (t == 0) begin
        lit = '0; lit[511:480] = 32'h61626380; lit[63:0] = 64'd24;
        n_tests++;
        if (outq.size() < 1 || outq[0].d !== lit || outq[0].l !== 1'b1) begin
          n_fail++; $display("FAIL abc_literal actual=%0d blocks required=1 block %h", outq.size(), lit[511:448]);
        end
      end
    end
  endtask

  task automatic test_random;
    int            g, bw, lw, n;
    longint        e;
    logic [127:0]  L;
    bp = 1'b1;
    stab_bad = 0;
    for (int t = 0; t < 40; t++) begin
      g = $urandom_range(0, 1);
      bw = (g != 0) ? 1024 : 512;
      lw = (g != 0) ? 128 : 64;
      case ($urandom_range(0, 5))
        0: L = 0;
        1: L = 128'(bw - lw - 2 + $urandom_range(0, 3));
        2: L = 128'(bw * $urandom_range(1, 3));
        3: L = 128'(bw * $urandom_range(1, 3) - 1 + $urandom_range(0, 2));
        4: L = 128'($urandom_range(1, 4 * bw));
        default: L = 128'($urandom_range(1, 64));
      endcase
      e = longint'((L + 128'(bw) - 1) / bw);
      if (e == 0) e = 1;
      n = int'(e);
      if ($urandom_range(0, 7) == 0) n = n + 1;
      else if (n > 1 && $urandom_range(0, 7) == 0) n = n - 1;
      msgq.delete();
      for (int i = 0; i < n; i++) msgq.push_back(rand_blk(g));
      send_msg(g, L);
      n_tests++;
      if (outq.size() != expq.size()) begin
        n_fail++; $display("FAIL rnd%0d_count g=%0d L=%0d actual=%0d required=%0d", t, g, L, outq.size(), expq.size());
      end
      for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
        n_tests++;
        if (outq[i].d !== expq[i].d || outq[i].l !== expq[i].l) begin
          n_fail++;
          $display("FAIL rnd%0d_blk%0d g=%0d L=%0d actual=%h..%h/%b required=%h..%h/%b", t, i, g, L,
                   outq[i].d[511:448], outq[i].d[63:0], outq[i].l,
                   expq[i].d[511:448], expq[i].d[63:0], expq[i].l);
        end
      end
      n_tests++;
      if (err_seen != exp_err) begin
        n_fail++; $display("FAIL rnd%0d_err g=%0d L=%0d n=%0d actual=%0d required=%0d", t, g, L, n, err_seen, exp_err);
      end
    end
    n_tests++;
    if (stab_bad != 0) begin n_fail++; $display("FAIL stall_stability actual=%0d changes required=0", stab_bad); end
  endtask

  task automatic test_back_to_back;
    bit ca, da;
    bp = 1'b0;
    msgq.delete();
    for (int i = 0; i < 4; i++) msgq.push_back(rand_blk(0));
    outq.delete();
    err_seen = 0;
    build_expect(0, 128'(4 * 512 - 100));
    send_cfg(0, 128'(4 * 512 - 100));
    for (int i = 0; i < 4; i++) begin
      data_in = msgq[i];
      din_last = (i == 3);
      din_valid[0] = 1'b1;
      tick(0, ca, da);
      n_tests++;
      if (da !== 1'b1) begin n_fail++; $display("FAIL b2b_accept beat=%0d actual=%b required=1", i, da); end
      if (i == 0) begin
        n_tests++;
        if (dout_valid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_latency actual=%b required=1", dout_valid[0]); end
      end
    end
    din_valid[0] = 1'b0;
    din_last = 1'b0;
    drain(0);
    n_tests++;
    if (outq.size() != expq.size()) begin
      n_fail++; $display("FAIL b2b_count actual=%0d required=%0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_tests++;
      if (outq[i].d !== expq[i].d || outq[i].l !== expq[i].l) begin
        n_fail++;
        $display("FAIL b2b_blk%0d actual=%h/%b required=%h/%b", i, outq[i].d[63:0], outq[i].l,
                 expq[i].d[63:0], expq[i].l);
      end
    end
  endtask

  task automatic test_reset_mid;
    bp = 1'b1;
    msgq.delete();
    for (int i = 0; i < 3; i++) msgq.push_back(rand_blk(0));
    send_cfg(0, 128'd1536);
    send_beats(0, 0, 2);
    nrst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests += 6;
    if (dout_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid actual=%b required=0", dout_valid[0]); end
    if (dout_last[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last actual=%b required=0", dout_last[0]); end
    if (dout0 !== '0) begin n_fail++; $display("FAIL mid_rst_data actual=%h required=0", dout0[63:0]); end
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err actual=%b required=0", err[0]); end
    if (cfg_ready[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cfg_ready actual=%b required=0", cfg_ready[0]); end
    if (din_ready[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_din_ready actual=%b required=0", din_ready[0]); end
    nrst = 1'b0;
    @(negedge clk);
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    msgq.delete();
    msgq.push_back(rand_blk(0));
    send_msg(0, 128'd300);
    n_tests++;
    if (outq.size() != expq.size()) begin
      n_fail++; $display("FAIL post_rst_count actual=%0d required=%0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_tests++;
      if (outq[i].d !== expq[i].d || outq[i].l !== expq[i].l) begin
        n_fail++;
        $display("FAIL post_rst_blk%0d actual=%h/%b required=%h/%b", i, outq[i].d[63:0], outq[i].l,
                 expq[i].d[63:0], expq[i].l);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; err_seen = 0; exp_err = 0; stab_bad = 0; bp = 1'b0;
    prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
    nrst = 1'b1;
    cfg_size = '0; data_in = '0; din_last = 1'b0;
    cfg_valid = '0; din_valid = '0; dout_ready = 2'b11;
    repeat (3) @(negedge clk);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
